// File: rtl/adder_io_pkg.sv
// Shared constants, error codes and FSM state type for the decimal operand loader.
package adder_io_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_NINE = 8'h39;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   localparam logic [1:0] ERR_NONE      = 2'b00;
   localparam logic [1:0] ERR_NON_DIGIT = 2'b01;
   localparam logic [1:0] ERR_RANGE     = 2'b10;
   localparam logic [1:0] ERR_BAD_TERM  = 2'b11;

   typedef enum logic [2:0] {
      X_TENS,
      X_ONES,
      X_TERM,
      Y_TENS,
      Y_ONES,
      Y_TERM,
      PRESENT,
      DRAIN
   } state_t;

   // Two decimal digits never exceed 99, so 7 bits hold the result without overflow.
   function automatic logic [6:0] dec2_value(input logic [3:0] tens, input logic [3:0] ones);
      return (7'(tens) * 7'd10) + 7'(ones);
   endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII character to decimal digit decoder.
module ascii_digit_decode
   import adder_io_pkg::*;
(
   input  logic [7:0] char_i,
   output logic       is_digit_o,
   output logic [3:0] value_o
);

   always_comb begin
      is_digit_o = (char_i >= ASCII_ZERO) && (char_i <= ASCII_NINE);
      value_o    = is_digit_o ? 4'(char_i - ASCII_ZERO) : 4'd0;
   end

endmodule

// File: rtl/decimal_operand_loader.sv
// Parses "DD\nDD\n" ASCII text into an X/Y operand pair for a small adder,
// flagging malformed or out-of-range input with a one-cycle error pulse.
module decimal_operand_loader
   import adder_io_pkg::*;
#(
   parameter int OPW = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           char_valid,
   input  logic [7:0]     char_data,
   output logic           char_ready,
   output logic [OPW-1:0] op_x,
   output logic [OPW-1:0] op_y,
   output logic           op_valid,
   input  logic           op_ready,
   output logic           err_valid,
   output logic [1:0]     err_code,
   output state_t         dbg_state
);

   localparam int OP_MAX = (1 << OPW) - 1;

   state_t         state_q;
   logic [3:0]     tens_q;
   logic [6:0]     val_q;
   logic [6:0]     val_d;
   logic [OPW-1:0] op_x_q;
   logic [OPW-1:0] op_y_q;
   logic           op_valid_q;
   logic           err_valid_q;
   logic [1:0]     err_code_q;

   logic           is_digit;
   logic [3:0]     digit_val;
   logic           is_lf;
   logic           accept;
   logic           err_hit;
   logic [1:0]     err_code_d;

   ascii_digit_decode u_decode (
      .char_i     (char_data),
      .is_digit_o (is_digit),
      .value_o    (digit_val)
   );

   // Handshakes: a character transfers on a cycle with char_valid && char_ready;
   // the operand pair transfers on a cycle with op_valid && op_ready.
   assign char_ready = (state_q != PRESENT);
   assign accept     = char_valid && char_ready;
   assign is_lf      = (char_data == ASCII_LF);
   assign val_d      = dec2_value(tens_q, digit_val);

   always_comb begin
      err_hit    = 1'b0;
      err_code_d = ERR_NONE;
      if (accept) begin
         case (state_q)
            X_TENS, X_ONES, Y_TENS, Y_ONES: begin
               err_hit    = !is_digit;
               err_code_d = ERR_NON_DIGIT;
            end
            X_TERM, Y_TERM: begin
               err_hit    = !is_lf || (int'(val_q) > OP_MAX);
               err_code_d = is_lf ? ERR_RANGE : ERR_BAD_TERM;
            end
            default: begin
               err_hit    = 1'b0;
               err_code_d = ERR_NONE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= X_TENS;
         tens_q      <= '0;
         val_q       <= '0;
         op_x_q      <= '0;
         op_y_q      <= '0;
         op_valid_q  <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         err_valid_q <= 1'b0;
         if (err_hit) begin
            // Any error throws away both operands; an LF culprit already ends the line.
            err_valid_q <= 1'b1;
            err_code_q  <= err_code_d;
            op_x_q      <= '0;
            op_y_q      <= '0;
            state_q     <= is_lf ? X_TENS : DRAIN;
         end else begin
            case (state_q)
               X_TENS, Y_TENS: if (accept) begin
                  tens_q  <= digit_val;
                  state_q <= (state_q == X_TENS) ? X_ONES : Y_ONES;
               end
               X_ONES, Y_ONES: if (accept) begin
                  val_q   <= val_d;
                  state_q <= (state_q == X_ONES) ? X_TERM : Y_TERM;
               end
               X_TERM: if (accept) begin
                  op_x_q  <= OPW'(val_q);
                  state_q <= Y_TENS;
               end
               Y_TERM: if (accept) begin
                  op_y_q     <= OPW'(val_q);
                  op_valid_q <= 1'b1;
                  state_q    <= PRESENT;
               end
               PRESENT: if (op_ready) begin
                  op_valid_q <= 1'b0;
                  state_q    <= X_TENS;
               end
               DRAIN: if (accept && is_lf) begin
                  state_q <= X_TENS;
               end
               default: state_q <= X_TENS;
            endcase
         end
      end
   end

   assign op_x      = op_x_q;
   assign op_y      = op_y_q;
   assign op_valid  = op_valid_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign dbg_state = state_q;

endmodule
